// File: rtl/ram_loader_pkg.sv
// Shared constants and FSM encoding for the SAP RAM serial loader.
// The RAM geometry here is the default the loader is built for.
package ram_loader_pkg;

    localparam int RAM_DATA_W = 8;
    localparam int RAM_ADDR_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SHIFT   = 3'd1,
        ST_WR_ADR  = 3'd2,
        ST_WR_DATA = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

endpackage

// File: rtl/ram_loader_serial_shift_in.sv
// MSB-first serial deserialiser: one bit per strobe, flags the strobe that
// completes a byte and presents the completed byte combinationally.
module serial_shift_in #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              enable,
    input  logic              strobe,
    input  logic              data,
    output logic              byte_valid,
    output logic [DATA_W-1:0] byte_out
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    // Only DATA_W-1 bits are stored: the final bit completes the byte directly.
    logic [DATA_W-2:0] shreg;
    logic [CNT_W-1:0]  bit_cnt;
    logic              last_bit;

    assign last_bit   = (bit_cnt == LAST_BIT);
    assign byte_valid = enable && strobe && last_bit;
    assign byte_out   = {shreg, data};

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (enable && strobe) begin
            shreg   <= {shreg[DATA_W-3:0], data};
            bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ram_loader.sv
// Serial program loader for the SAP RAM: collects bytes, writes each via the
// address-write then data-write bus cycles, and holds the CPU in reset meanwhile.
module ram_loader
    import ram_loader_pkg::*;
#(
    parameter int DATA_W = RAM_DATA_W,
    parameter int ADDR_W = RAM_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en,
    input  logic              ser_strobe,
    input  logic              ser_data,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_drive,
    output logic              mem_adr_we,
    output logic              mem_we,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output state_t            state_dbg,
    output logic [ADDR_W-1:0] addr_dbg
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] hold;
    logic              shift_clr;
    logic              byte_valid;
    logic [DATA_W-1:0] byte_data;

    assign shift_clr = (state == ST_IDLE) || !load_en;
    assign state_dbg = state;
    assign addr_dbg  = addr;

    serial_shift_in #(.DATA_W(DATA_W)) u_shift (
        .clk        (clk),
        .reset      (reset),
        .clear      (shift_clr),
        .enable     (busy),
        .strobe     (ser_strobe),
        .data       (ser_data),
        .byte_valid (byte_valid),
        .byte_out   (byte_data)
    );

    always_ff @(posedge clk) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Bytes can complete during a write cycle; hold is only reused 8+ cycles later.
    always_ff @(posedge clk) begin
        if (!reset) begin
            addr <= '0;
            hold <= '0;
        end else begin
            if (state == ST_IDLE)
                addr <= '0;
            else if (state == ST_WR_DATA && load_en && addr != LAST_ADDR)
                addr <= addr + 1'b1;
            if (byte_valid)
                hold <= byte_data;
        end
    end

    always_comb begin
        state_nxt  = state;
        bus_out    = '0;
        bus_drive  = 1'b0;
        mem_adr_we = 1'b0;
        mem_we     = 1'b0;
        cpu_hold   = 1'b1;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                cpu_hold = 1'b0;
                if (load_en) state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                busy = 1'b1;
                if (byte_valid) state_nxt = ST_WR_ADR;
            end
            ST_WR_ADR: begin
                busy       = 1'b1;
                bus_drive  = 1'b1;
                bus_out    = {{(DATA_W-ADDR_W){1'b0}}, addr};
                mem_adr_we = 1'b1;
                state_nxt  = ST_WR_DATA;
            end
            ST_WR_DATA: begin
                busy      = 1'b1;
                bus_drive = 1'b1;
                bus_out   = hold;
                mem_we    = 1'b1;
                state_nxt = (addr == LAST_ADDR) ? ST_DONE : ST_SHIFT;
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase
        // Abort beats everything, including a byte completing this cycle.
        if (!load_en) state_nxt = ST_IDLE;
    end

endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader with a small RAM model on the loader's bus.
module tb_ram_loader;
    import ram_loader_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       load_en = 1'b0;
    logic       ser_strobe = 1'b0;
    logic       ser_data = 1'b0;
    logic [7:0] bus_out;
    logic       bus_drive, mem_adr_we, mem_we, cpu_hold, busy, done;
    state_t     state_dbg;
    logic [3:0] addr_dbg;

    int passed = 0;
    int total  = 0;

    logic [7:0] ram [16];
    logic [3:0] mar = '0;
    int         wr_cnt = 0;
    int         adr_cnt = 0;
    int         viol = 0;

    ram_loader dut (
        .clk        (clk),
        .reset      (reset),
        .load_en    (load_en),
        .ser_strobe (ser_strobe),
        .ser_data   (ser_data),
        .bus_out    (bus_out),
        .bus_drive  (bus_drive),
        .mem_adr_we (mem_adr_we),
        .mem_we     (mem_we),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .state_dbg  (state_dbg),
        .addr_dbg   (addr_dbg)
    );

    always #5 clk = ~clk;

    initial for (int i = 0; i < 16; i++) ram[i] = 8'h00;

    // RAM model: address register then data write, as the machine memory does.
    always @(posedge clk) begin
        if (mem_adr_we) begin
            mar     <= bus_out[3:0];
            adr_cnt <= adr_cnt + 1;
        end
        if (mem_we) begin
            ram[mar] <= bus_out;
            wr_cnt   <= wr_cnt + 1;
        end
        if (reset === 1'b1 && ((mem_adr_we && mem_we) || ((mem_adr_we || mem_we) && !bus_drive)))
            viol <= viol + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic shift_byte(input logic [7:0] b, input int gap);
        for (int i = 7; i >= 0; i--) begin
            ser_strobe = 1'b1;
            ser_data   = b[i];
            tick();
            ser_strobe = 1'b0;
            if (i != 0) repeat (gap) tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; load_en = 1'b0;
        tick(); tick();
        total++; if ({bus_out, bus_drive, mem_adr_we, mem_we, cpu_hold, busy, done} !== 14'h0)
            $display("FAIL reset_outputs: got %h want 0", {bus_out, bus_drive, mem_adr_we, mem_we, cpu_hold, busy, done}); else passed++;
        total++; if (state_dbg !== ST_IDLE) $display("FAIL reset_state: got %0d want %0d", state_dbg, ST_IDLE); else passed++;
        reset = 1'b1; load_en = 1'b1;
        tick();
        total++; if ({cpu_hold, busy, bus_drive} !== 3'b110) $display("FAIL start_flags: got %b want 110", {cpu_hold, busy, bus_drive}); else passed++;
        total++; if (addr_dbg !== 4'd0) $display("FAIL start_addr: got %0d want 0", addr_dbg); else passed++;
    endtask

    task automatic test_single_byte();
        shift_byte(8'hA5, 2);
        total++; if ({mem_adr_we, mem_we, bus_drive} !== 3'b101) $display("FAIL wr_adr_strobes: got %b want 101", {mem_adr_we, mem_we, bus_drive}); else passed++;
        total++; if (bus_out !== 8'h00) $display("FAIL wr_adr_bus: got %h want 00", bus_out); else passed++;
        tick();
        total++; if ({mem_adr_we, mem_we, bus_drive} !== 3'b011) $display("FAIL wr_data_strobes: got %b want 011", {mem_adr_we, mem_we, bus_drive}); else passed++;
        total++; if (bus_out !== 8'hA5) $display("FAIL wr_data_bus: got %h want a5", bus_out); else passed++;
        tick();
        total++; if (ram[0] !== 8'hA5) $display("FAIL ram0_a5: got %h want a5", ram[0]); else passed++;
        total++; if (state_dbg !== ST_SHIFT || addr_dbg !== 4'd1) $display("FAIL after_write: got state %0d addr %0d want 1/1", state_dbg, addr_dbg); else passed++;
    endtask

    task automatic test_back_to_back();
        int wr0;
        logic [7:0] b;
        load_en = 1'b0; tick();
        load_en = 1'b1; tick();
        wr0 = wr_cnt;
        for (int k = 0; k < 128; k++) begin
            b = 8'h10 + 8'(k / 8);
            ser_strobe = 1'b1;
            ser_data   = b[7 - (k % 8)];
            tick();
        end
        ser_strobe = 1'b0;
        tick(); tick();
        total++; if ({done, busy, cpu_hold} !== 3'b101) $display("FAIL b2b_done: got %b want 101", {done, busy, cpu_hold}); else passed++;
        total++; if (wr_cnt - wr0 !== 16) $display("FAIL b2b_writes: got %0d want 16", wr_cnt - wr0); else passed++;
        for (int i = 0; i < 16; i++) begin
            total++; if (ram[i] !== 8'h10 + 8'(i)) $display("FAIL b2b_ram%0d: got %h want %h", i, ram[i], 8'h10 + 8'(i)); else passed++;
        end
    endtask

    task automatic test_done_ignore();
        int wr0;
        int adr0;
        wr0 = wr_cnt; adr0 = adr_cnt;
        repeat (10) begin
            ser_strobe = 1'b1; ser_data = 1'b1; tick();
            ser_strobe = 1'b0; tick();
        end
        total++; if (done !== 1'b1 || state_dbg !== ST_DONE) $display("FAIL done_held: got done %b state %0d want 1/%0d", done, state_dbg, ST_DONE); else passed++;
        total++; if (wr_cnt != wr0 || adr_cnt != adr0) $display("FAIL done_no_write: got %0d/%0d want %0d/%0d", wr_cnt, adr_cnt, wr0, adr0); else passed++;
        load_en = 1'b0;
        tick();
        total++; if (done !== 1'b0) $display("FAIL done_clear: got %b want 0", done); else passed++;
        tick();
        total++; if (cpu_hold !== 1'b0) $display("FAIL done_release: got %b want 0", cpu_hold); else passed++;
    endtask

    task automatic test_abort_mid_byte();
        load_en = 1'b1; tick();
        shift_byte(8'h3C, 0); tick(); tick();
        shift_byte(8'hC3, 0); tick(); tick();
        shift_byte(8'h5A, 0); tick(); tick();
        for (int i = 0; i < 4; i++) begin
            ser_strobe = 1'b1; ser_data = 1'b1; tick();
        end
        ser_strobe = 1'b0;
        load_en = 1'b0;
        tick();
        total++; if (state_dbg !== ST_IDLE || busy !== 1'b0) $display("FAIL abort_idle: got state %0d busy %b want 0/0", state_dbg, busy); else passed++;
        tick();
        total++; if (cpu_hold !== 1'b0) $display("FAIL abort_release: got %b want 0", cpu_hold); else passed++;
        total++; if ({ram[0], ram[1], ram[2], ram[3]} !== 32'h3CC35A13)
            $display("FAIL abort_ram: got %h want 3cc35a13", {ram[0], ram[1], ram[2], ram[3]}); else passed++;
        load_en = 1'b1; tick();
        total++; if (addr_dbg !== 4'd0 || state_dbg !== ST_SHIFT) $display("FAIL reload_start: got addr %0d state %0d want 0/1", addr_dbg, state_dbg); else passed++;
        shift_byte(8'h77, 0);
        total++; if (mem_adr_we !== 1'b1 || bus_out !== 8'h00) $display("FAIL reload_adr: got we %b bus %h want 1/00", mem_adr_we, bus_out); else passed++;
        tick();
        total++; if (mem_we !== 1'b1 || bus_out !== 8'h77) $display("FAIL reload_data: got we %b bus %h want 1/77", mem_we, bus_out); else passed++;
        tick();
        total++; if (ram[0] !== 8'h77) $display("FAIL reload_ram0: got %h want 77", ram[0]); else passed++;
    endtask

    task automatic test_abort_on_strobe();
        int wr0;
        int adr0;
        logic [7:0] b;
        b = 8'h99;
        wr0 = wr_cnt; adr0 = adr_cnt;
        for (int i = 7; i >= 1; i--) begin
            ser_strobe = 1'b1; ser_data = b[i]; tick();
        end
        ser_data = b[0];
        load_en  = 1'b0;
        tick();
        ser_strobe = 1'b0;
        total++; if (state_dbg !== ST_IDLE || {mem_adr_we, mem_we} !== 2'b00)
            $display("FAIL abort8_state: got state %0d we %b want 0/00", state_dbg, {mem_adr_we, mem_we}); else passed++;
        tick(); tick();
        total++; if (wr_cnt != wr0 || adr_cnt != adr0) $display("FAIL abort8_no_write: got %0d/%0d want %0d/%0d", wr_cnt, adr_cnt, wr0, adr0); else passed++;
        total++; if (ram[1] !== 8'hC3) $display("FAIL abort8_ram1: got %h want c3", ram[1]); else passed++;
    endtask

    task automatic test_mid_reset();
        load_en = 1'b1; tick();
        for (int i = 0; i < 3; i++) begin
            ser_strobe = 1'b1; ser_data = 1'b1; tick();
        end
        ser_strobe = 1'b0;
        reset = 1'b0;
        tick();
        total++; if (state_dbg !== ST_IDLE || {cpu_hold, busy, done, bus_drive} !== 4'b0000)
            $display("FAIL mid_reset: got state %0d flags %b want 0/0000", state_dbg, {cpu_hold, busy, done, bus_drive}); else passed++;
        reset = 1'b1; load_en = 1'b0;
        tick();
        total++; if (viol != 0) $display("FAIL strobe_rules: got %0d violations want 0", viol); else passed++;
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_done_ignore();
        test_abort_mid_byte();
        test_abort_on_strobe();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
